// File: rtl/fan_cmd_scheduler.sv
// Arbitrates two command requesters into a 4-deep FIFO and replays each
// command REPEAT_COUNT times to the fan packet generator with fixed spacing.
module fan_cmd_scheduler #(
    parameter int REPEAT_COUNT  = 4,
    parameter int PACKET_CYCLES = 90000,
    parameter int GAP_CYCLES    = 20000
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic [2:0] a_cmd,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [2:0] b_cmd,
    output logic       b_ready,
    input  logic       flush,
    output logic       gen_start,
    output logic [2:0] gen_cmd,
    output logic       busy,
    output logic [2:0] fifo_count,
    output logic       bad_cmd,
    output logic [1:0] fsm_state
);

    localparam int TIMER_MAX = (PACKET_CYCLES > GAP_CYCLES) ? PACKET_CYCLES : GAP_CYCLES;
    localparam int TW        = $clog2(TIMER_MAX) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      mem [4];
    logic [1:0]      wr_ptr, rd_ptr;
    logic [2:0]      count_q;
    logic            avail_q;
    logic            last_b_q;
    logic            bad_q;
    logic            cancel_q;
    logic [TW-1:0]   timer_q;
    logic [3:0]      rep_left_q;
    logic [2:0]      gen_cmd_q;

    logic            space, a_hs, b_hs, accept, push, pop, timer_zero;
    logic [2:0]      cmd_in;

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; ready never depends on the port's own valid, and at most one port is
    // ready when both are valid (round-robin, favouring the port not served last).
    assign space   = (count_q != 3'd4) && !flush;
    assign a_ready = space && (!b_valid || last_b_q);
    assign b_ready = space && (!a_valid || !last_b_q);
    assign a_hs    = a_valid && a_ready;
    assign b_hs    = b_valid && b_ready;
    assign accept  = a_hs || b_hs;
    assign cmd_in  = a_hs ? a_cmd : b_cmd;
    assign push    = accept && (cmd_in <= 3'd4);

    // Occupancy is re-registered before the scheduler acts on it, so a freshly
    // pushed command starts two edges after its handshake.
    assign pop        = (state_q == S_IDLE) && (count_q != 3'd0) && avail_q && !flush;
    assign timer_zero = (timer_q == '0);

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count_q  <= 3'd0;
            avail_q  <= 1'b0;
            last_b_q <= 1'b1;
            bad_q    <= 1'b0;
        end else begin
            bad_q   <= accept && (cmd_in > 3'd4);
            avail_q <= (count_q != 3'd0);
            if (accept) last_b_q <= b_hs;
            if (flush) begin
                wr_ptr  <= 2'd0;
                rd_ptr  <= 2'd0;
                count_q <= 3'd0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= cmd_in;
                    wr_ptr      <= wr_ptr + 2'd1;
                end
                if (pop) rd_ptr <= rd_ptr + 2'd1;
                count_q <= count_q + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = S_START;
            S_START: state_d = S_SEND;
            S_SEND:  if (timer_zero) state_d = S_GAP;
            S_GAP: begin
                if (timer_zero)
                    state_d = ((rep_left_q > 4'd1) && !cancel_q && !flush) ? S_START : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            timer_q    <= '0;
            rep_left_q <= 4'd0;
            cancel_q   <= 1'b0;
            gen_cmd_q  <= 3'd0;
        end else begin
            // A flush while busy lets the current packet and gap finish, then stops.
            if (state_d == S_IDLE) cancel_q <= 1'b0;
            else if (flush)        cancel_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        gen_cmd_q  <= mem[rd_ptr];
                        rep_left_q <= 4'(REPEAT_COUNT);
                    end
                end
                S_START: timer_q <= TW'(PACKET_CYCLES - 1);
                S_SEND:  timer_q <= timer_zero ? TW'(GAP_CYCLES - 1) : timer_q - 1'b1;
                S_GAP: begin
                    if (!timer_zero)              timer_q    <= timer_q - 1'b1;
                    else if (state_d == S_START)  rep_left_q <= rep_left_q - 4'd1;
                end
                default: timer_q <= '0;
            endcase
        end
    end

    always_comb begin
        gen_start  = (state_q == S_START);
        busy       = (state_q != S_IDLE);
        gen_cmd    = gen_cmd_q;
        fifo_count = count_q;
        bad_cmd    = bad_q;
        fsm_state  = state_q;
    end

endmodule

// File: tb/tb_fan_cmd_scheduler.sv
// Directed bench for fan_cmd_scheduler with short packet/gap timing; expected
// cycle positions are hand-derived from the timing rules.
module tb_fan_cmd_scheduler;

    logic       ref_clk = 1'b0;
    logic       reset, a_valid, b_valid, flush;
    logic [2:0] a_cmd, b_cmd;
    logic       a_ready, b_ready, gen_start, busy, bad_cmd;
    logic [2:0] gen_cmd, fifo_count;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2:0] exp_q[$];

    fan_cmd_scheduler #(
        .REPEAT_COUNT (3),
        .PACKET_CYCLES(10),
        .GAP_CYCLES   (5)
    ) dut (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_cmd     (a_cmd),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_cmd     (b_cmd),
        .b_ready   (b_ready),
        .flush     (flush),
        .gen_start (gen_start),
        .gen_cmd   (gen_cmd),
        .busy      (busy),
        .fifo_count(fifo_count),
        .bad_cmd   (bad_cmd),
        .fsm_state (fsm_state)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic align();
        @(posedge ref_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_busy;
        logic found;

        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
        a_cmd = 3'd0; b_cmd = 3'd0;
        repeat (2) @(posedge ref_clk);
        @(negedge ref_clk);
        check_eq("rst_gen_start", gen_start, 0);
        check_eq("rst_gen_cmd", gen_cmd, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fifo_count", fifo_count, 0);
        check_eq("rst_bad_cmd", bad_cmd, 0);
        check_eq("rst_state", fsm_state, 0);
        check_eq("rst_a_ready", a_ready, 1);
        check_eq("rst_b_ready", b_ready, 1);
        reset = 1'b0;
        repeat (2) align();

        // Single command: starts at cycles 2, 18, 34; idle again at 50.
        a_valid = 1'b1; a_cmd = 3'd2;
        align();
        a_valid = 1'b0;
        for (int k = 0; k <= 52; k++) begin
            @(negedge ref_clk);
            check_eq($sformatf("single_gen_start_c%0d", k), gen_start, (k == 2 || k == 18 || k == 34));
            check_eq($sformatf("single_busy_c%0d", k), busy, (k >= 2 && k <= 49));
            if (k == 0) check_eq("single_count_c0", fifo_count, 1);
            if (k == 2) check_eq("single_count_c2", fifo_count, 0);
            if (k >= 2) check_eq($sformatf("single_gen_cmd_c%0d", k), gen_cmd, 2);
            if (k == 1) check_eq("single_bad_cmd", bad_cmd, 0);
        end

        // Out-of-range command from B: flagged and dropped.
        align();
        b_valid = 1'b1; b_cmd = 3'd6;
        align();
        b_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ref_clk);
            check_eq($sformatf("bad_pulse_c%0d", k), bad_cmd, (k == 0));
            check_eq($sformatf("bad_count_c%0d", k), fifo_count, 0);
            check_eq($sformatf("bad_gen_start_c%0d", k), gen_start, 0);
        end

        // Both ports valid every cycle: A,B,A,B,A accepted until full.
        align();
        a_valid = 1'b1; a_cmd = 3'd1;
        b_valid = 1'b1; b_cmd = 3'd3;
        for (int k = 0; k <= 6; k++) begin
            logic [6:0] exp_a;
            logic [6:0] exp_b;
            logic [2:0] exp_c [7];
            exp_a = 7'b0010101;
            exp_b = 7'b0001010;
            exp_c = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4};
            @(negedge ref_clk);
            check_eq($sformatf("rr_a_ready_e%0d", k), a_ready, exp_a[k]);
            check_eq($sformatf("rr_b_ready_e%0d", k), b_ready, exp_b[k]);
            check_eq($sformatf("rr_count_e%0d", k), fifo_count, exp_c[k]);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("rr_first_cmd", gen_cmd, 1);

        // Full FIFO popping while A offers: blocked this cycle, accepted the next.
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ref_clk);
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("full_idle_reached", found, 1);
        check_eq("full_count_before_pop", fifo_count, 4);
        a_valid = 1'b1; a_cmd = 3'd4;
        #1;
        check_eq("full_a_ready_blocked", a_ready, 0);
        @(negedge ref_clk);
        check_eq("full_count_after_pop", fifo_count, 3);
        check_eq("full_a_ready_free", a_ready, 1);
        check_eq("full_gen_start", gen_start, 1);
        check_eq("full_gen_cmd", gen_cmd, 3);
        align();
        a_valid = 1'b0;
        @(negedge ref_clk);
        check_eq("full_count_refill", fifo_count, 4);

        // Remaining commands must come out in arrival order.
        exp_q = '{3'd1, 3'd3, 3'd1, 3'd4};
        prev_busy = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge ref_clk);
            if (gen_start && !prev_busy) begin
                if (exp_q.size() > 0) check_eq("order_gen_cmd", gen_cmd, exp_q.pop_front());
                else check_eq("order_extra_cmd", gen_cmd, 8);
            end
            prev_busy = busy;
            if (exp_q.size() == 0 && !busy) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("order_drained", found, 1);
        check_eq("order_queue_left", exp_q.size(), 0);

        // Flush during second packet of cmd 1: packet and gap finish, cmd 3 discarded.
        align();
        a_valid = 1'b1; a_cmd = 3'd1;
        align();
        a_cmd = 3'd3;
        align();
        a_valid = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge ref_clk);
            if (k == 21) flush = 1'b0;
            check_eq($sformatf("flush_gen_start_c%0d", k), gen_start, (k == 2 || k == 18));
            check_eq($sformatf("flush_busy_c%0d", k), busy, (k >= 2 && k <= 33));
            if (k == 1)  check_eq("flush_count_c1", fifo_count, 2);
            if (k == 20) check_eq("flush_count_c20", fifo_count, 1);
            if (k >= 21) check_eq($sformatf("flush_count_c%0d", k), fifo_count, 0);
            if (k == 20) begin
                flush = 1'b1;
                #1;
                check_eq("flush_a_ready", a_ready, 0);
                check_eq("flush_b_ready", b_ready, 0);
            end
        end

        // Reset during SEND aborts at once.
        align();
        a_valid = 1'b1; a_cmd = 3'd4;
        align();
        a_cmd = 3'd2;
        align();
        a_valid = 1'b0;
        for (int k = 1; k <= 106; k++) begin
            @(negedge ref_clk);
            if (k == 5) begin
                check_eq("rsend_busy_before", busy, 1);
                check_eq("rsend_state_before", fsm_state, 2);
                check_eq("rsend_count_before", fifo_count, 1);
                reset = 1'b1;
            end else if (k == 6) begin
                check_eq("rsend_busy", busy, 0);
                check_eq("rsend_gen_cmd", gen_cmd, 0);
                check_eq("rsend_count", fifo_count, 0);
                check_eq("rsend_state", fsm_state, 0);
                reset = 1'b0;
            end else if (k > 6) begin
                check_eq($sformatf("rsend_gen_start_c%0d", k), gen_start, 0);
                check_eq($sformatf("rsend_busy_c%0d", k), busy, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
